// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, FSM states, flag bit positions.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_RL  = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  // Bit positions inside the {n,v,z} flag register.
  localparam int unsigned Z = 0;
  localparam int unsigned V = 1;
  localparam int unsigned N = 2;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned radix-2 shift-add multiplier. One partial product per cycle;
// done is asserted during the last step and product then shows the final sum.
module alu_mul_seq #(
  parameter int unsigned DSIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DSIZE-1:0]     a,
  input  logic [DSIZE-1:0]     b,
  output logic                 done,
  output logic [2*DSIZE-1:0]   product
);

  localparam int unsigned CW = $clog2(DSIZE);

  logic [2*DSIZE-1:0] mcand_q, mcand_d;
  logic [2*DSIZE-1:0] acc_q, acc_d;
  logic [DSIZE-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               last;

  assign last = (cnt_q == CW'(DSIZE - 1));

  // Next-state: load operands on start, then add-and-shift one multiplier bit per cycle.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start) begin
      mcand_d  = {{DSIZE{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last) begin
        run_d = 1'b0;
      end
    end
  end

  // The final step's sum is handed out combinationally so the caller loads it on the same edge.
  assign done    = run_q & last;
  assign product = acc_d;

  // State register with synchronous reset; reset abandons any multiply in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU stage between register read and write-back. Single-cycle ops load the
// output register on accept; MUL runs the iterative multiplier for DSIZE cycles first.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned DSIZE = 16,
  parameter int unsigned SHW   = $clog2(DSIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  logic [3:0]       op,
  input  logic [SHW-1:0]   imm,
  input  logic             flag_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out,
  output logic [2:0]       flag,
  output logic             busy
);

  localparam int unsigned M = DSIZE - 1;

  state_e             state_q, state_d;
  logic [DSIZE-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic [2:0]         flag_q, flag_d;
  logic               fen_q, fen_d;
  logic               neg_q, neg_d;

  logic               xfer;
  logic [DSIZE-1:0]   sum, diff;
  logic [2*DSIZE-1:0] rot;
  logic [DSIZE-1:0]   alu_res;
  logic [2:0]         alu_flag;
  logic               alu_upd;

  logic [DSIZE-1:0]   a_mag, b_mag;
  logic               mul_start, mul_done;
  logic [2*DSIZE-1:0] mul_prod, mul_full;
  logic [DSIZE-1:0]   mul_res;
  logic [2:0]         mul_flag;
  logic               mul_v;

  assign busy      = (state_q == MUL);
  assign in_ready  = rst_n & ~busy & (~out_valid_q | out_ready);
  assign xfer      = in_valid & in_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign flag      = flag_q;

  // Single-cycle datapath: result plus the flags it would commit, and whether it commits any.
  always_comb begin
    alu_res  = '0;
    alu_flag = '0;
    alu_upd  = 1'b0;
    sum      = a + b;
    diff     = a - b;
    // Rotate by shifting a doubled copy; the upper half is the rotated word.
    rot      = {a, a} << imm;
    case (op)
      OP_ADD: begin
        alu_res     = sum;
        alu_upd     = 1'b1;
        alu_flag[V] = (a[M] == b[M]) & (sum[M] != a[M]);
        alu_flag[N] = ~alu_flag[V] & sum[M];
        alu_flag[Z] = (sum == '0);
      end
      OP_SUB: begin
        alu_res     = diff;
        alu_upd     = 1'b1;
        alu_flag[V] = (a[M] != b[M]) & (diff[M] != a[M]);
        alu_flag[N] = ~alu_flag[V] & diff[M];
        alu_flag[Z] = (diff == '0);
      end
      OP_AND: begin
        alu_res     = a & b;
        alu_upd     = 1'b1;
        alu_flag[Z] = ((a & b) == '0);
      end
      OP_OR: begin
        alu_res     = a | b;
        alu_upd     = 1'b1;
        alu_flag[Z] = ((a | b) == '0);
      end
      OP_SLL:  alu_res = a << imm;
      OP_SRL:  alu_res = a >> imm;
      OP_SRA:  alu_res = $signed(a) >>> imm;
      OP_RL:   alu_res = rot[2*DSIZE-1:DSIZE];
      default: alu_res = '0;
    endcase
  end

  // Multiplier works on magnitudes; sign is reapplied to the full-width product.
  always_comb begin
    a_mag         = a[M] ? -a : a;
    b_mag         = b[M] ? -b : b;
    mul_full      = neg_q ? -mul_prod : mul_prod;
    mul_res       = mul_full[DSIZE-1:0];
    // Fits in DSIZE signed bits only if the top DSIZE+1 bits are all equal.
    mul_v         = ~((&mul_full[2*DSIZE-1:M]) | ~(|mul_full[2*DSIZE-1:M]));
    mul_flag      = '0;
    mul_flag[Z]   = (mul_res == '0);
    mul_flag[V]   = mul_v;
    mul_flag[N]   = ~mul_v & mul_res[M];
  end

  alu_mul_seq #(
    .DSIZE (DSIZE)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a_mag),
    .b       (b_mag),
    .done    (mul_done),
    .product (mul_prod)
  );

  // FSM next-state and output-register loads.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q & ~out_ready;
    flag_d      = flag_q;
    fen_d       = fen_q;
    neg_d       = neg_q;
    mul_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            fen_d     = flag_en;
            neg_d     = a[M] ^ b[M];
            state_d   = MUL;
          end else begin
            out_d       = alu_res;
            out_valid_d = 1'b1;
            if (flag_en && alu_upd) begin
              flag_d = alu_flag;
            end
          end
        end
      end
      MUL: begin
        // The output register was freed on entry, so out_ready is not consulted here.
        if (mul_done) begin
          out_d       = mul_res;
          out_valid_d = 1'b1;
          if (fen_q) begin
            flag_d = mul_flag;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      flag_q      <= '0;
      fen_q       <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      flag_q      <= flag_d;
      fen_q       <= fen_d;
      neg_q       <= neg_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (DSIZE=16): directed vectors push expected {out,flag};
// a negedge monitor pops and compares on every output handshake.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic [3:0]  op;
  logic [3:0]  imm;
  logic        flag_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [2:0]  flag;
  logic        busy;

  typedef struct packed {
    logic [15:0] o;
    logic [2:0]  f;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(
    .DSIZE (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .imm       (imm),
    .flag_en   (flag_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flag      (flag),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  // Monitor: every accepted output must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %h/%b required none", out, flag);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (out !== e.o || flag !== e.f) begin
          errors++;
          $display("FAIL result got out=%h flag=%b required out=%h flag=%b", out, flag, e.o, e.f);
        end
      end
    end
  end

  // Drive one op (called at posedge+1); returns at posedge+1 after the accept edge.
  task automatic send(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                      input logic [3:0] iv, input logic fen, input logic push,
                      input logic [15:0] eo, input logic [2:0] ef);
    int  n;
    logic acc;
    exp_t e;
    if (push) begin
      e.o = eo;
      e.f = ef;
      sb_q.push_back(e);
    end
    op = o; a = av; b = bv; imm = iv; flag_en = fen; in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0; imm = '0; flag_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_flag", 32'(flag), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // op, a, b, imm, flag_en, push, expected out, expected {n,v,z}
    send(4'd0, 16'h7FFF, 16'h0001, 4'd0,  1'b1, 1'b1, 16'h8000, 3'b010);
    send(4'd1, 16'h0005, 16'h0005, 4'd0,  1'b1, 1'b1, 16'h0000, 3'b001);
    send(4'd4, 16'h0001, 16'h0000, 4'd15, 1'b1, 1'b1, 16'h8000, 3'b001);
    send(4'd7, 16'h8001, 16'h0000, 4'd0,  1'b0, 1'b1, 16'h8001, 3'b001);
    send(4'd7, 16'h8001, 16'h0000, 4'd4,  1'b0, 1'b1, 16'h0018, 3'b001);
    send(4'd6, 16'h8000, 16'h0000, 4'd15, 1'b0, 1'b1, 16'hFFFF, 3'b001);
    send(4'd5, 16'h8000, 16'h0000, 4'd15, 1'b1, 1'b1, 16'h0001, 3'b001);
    send(4'd1, 16'h0003, 16'h0005, 4'd0,  1'b1, 1'b1, 16'hFFFE, 3'b100);
    send(4'd1, 16'h8000, 16'h0001, 4'd0,  1'b1, 1'b1, 16'h7FFF, 3'b010);
    send(4'd2, 16'hF0F0, 16'h0F0F, 4'd0,  1'b1, 1'b1, 16'h0000, 3'b001);
    send(4'd3, 16'h8000, 16'h0001, 4'd0,  1'b1, 1'b1, 16'h8001, 3'b000);
    send(4'd9, 16'h1234, 16'h0000, 4'd0,  1'b1, 1'b1, 16'h0000, 3'b000);
    send(4'd0, 16'hFFFF, 16'h0001, 4'd0,  1'b0, 1'b1, 16'h0000, 3'b000);

    // MUL -3*7: busy for 16 cycles, result on the 17th edge counting the accept.
    send(4'd8, 16'hFFFD, 16'h0007, 4'd0, 1'b1, 1'b1, 16'hFFEB, 3'b100);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("mul_busy", 32'(busy), 32'h1);
      chk("mul_in_ready", 32'(in_ready), 32'h0);
    end
    @(negedge clk);
    chk("mul_done_valid", 32'(out_valid), 32'h1);
    chk("mul_done_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;

    // MUL overflow with downstream stalled.
    send(4'd8, 16'h0100, 16'h0100, 4'd0, 1'b1, 1'b1, 16'h0000, 3'b011);
    out_ready = 1'b0;
    begin
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("mul2_arrives", 32'(out_valid), 32'h1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out", 32'(out), 32'h0);
      chk("stall_flag", 32'(flag), 32'h3);
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("stall_in_ready", 32'(in_ready), 32'h0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'd0, 16'h0010, 16'h0020, 4'd0, 1'b0, 1'b1, 16'h0030, 3'b011);
    @(negedge clk);
    chk("b2b_valid", 32'(out_valid), 32'h1);
    @(posedge clk); #1;

    // Reset at MUL cycle 8 abandons the multiply.
    send(4'd8, 16'h0005, 16'h0003, 4'd0, 1'b1, 1'b0, 16'h0000, 3'b000);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("mrst_out", 32'(out), 32'h0);
    chk("mrst_flag", 32'(flag), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("mrst_no_result", 32'(out_valid), 32'h0);
    send(4'd0, 16'h0002, 16'h0003, 4'd0, 1'b1, 1'b1, 16'h0005, 3'b000);

    begin
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
